// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write arbiter: register id width,
// the hard-wired zero register and the aging FSM states.
package rf_pkg;

    localparam int REG_ID_W = 4;
    localparam logic [REG_ID_W-1:0] REG_ZERO = 4'h0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } age_state_t;

endpackage

// File: rtl/rf_wr_fifo2.sv
// Two-entry FIFO holding {reg, data} for the memory-return write path.
// Pushes into a full FIFO are dropped even when a pop happens in the same cycle.
module rf_wr_fifo2
    import rf_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic [REG_ID_W-1:0] push_reg,
    input  logic [DATA_W-1:0]   push_data,
    output logic                full,
    output logic                empty,
    output logic [REG_ID_W-1:0] head_reg,
    output logic [DATA_W-1:0]   head_data
);

    logic [REG_ID_W-1:0] mem_reg  [2];
    logic [DATA_W-1:0]   mem_data [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          count;
    logic                do_push;
    logic                do_pop;

    assign full      = (count == 2'd2);
    assign empty     = (count == 2'd0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_reg  = mem_reg[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem_reg[wr_ptr]  <= push_reg;
            mem_data[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the register file's single write port between the writeback stage
// (req0, fixed priority) and buffered memory returns (req1, aging-protected).
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                v0,
    output logic                rdy0,
    input  logic [REG_ID_W-1:0] reg0,
    input  logic [DATA_W-1:0]   data0,
    input  logic                v1,
    output logic                rdy1,
    input  logic [REG_ID_W-1:0] reg1,
    input  logic [DATA_W-1:0]   data1,
    output logic                wr_en,
    output logic [REG_ID_W-1:0] wr_reg,
    output logic [DATA_W-1:0]   wr_data,
    output logic                busy
);

    localparam int AGE_W = $clog2(MAX_WAIT + 1);

    // Handshakes: req1 pushes on v1 && rdy1, req0 is consumed on v0 && rdy0;
    // each producer holds its valid and payload stable until accepted.
    age_state_t          state;
    age_state_t          state_nxt;
    logic [AGE_W-1:0]    age;
    logic [AGE_W-1:0]    age_nxt;

    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic [REG_ID_W-1:0] head_reg;
    logic [DATA_W-1:0]   head_data;
    logic                grant;
    logic [REG_ID_W-1:0] grant_reg;
    logic [DATA_W-1:0]   grant_data;
    logic                remaining;

    assign rdy1 = !full;
    assign busy = !empty;
    assign rdy0 = (state != FORCE);
    assign push = v1 && !full;
    // After a pop the FIFO still holds an entry if it was full or is refilled now.
    assign remaining = full || push;

    rf_wr_fifo2 #(
        .DATA_W(DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_reg  (reg1),
        .push_data (data1),
        .full      (full),
        .empty     (empty),
        .head_reg  (head_reg),
        .head_data (head_data)
    );

    always_comb begin
        grant      = 1'b0;
        pop        = 1'b0;
        grant_reg  = reg0;
        grant_data = data0;
        if (state == FORCE) begin
            grant      = !empty;
            pop        = !empty;
            grant_reg  = head_reg;
            grant_data = head_data;
        end else if (v0) begin
            grant = 1'b1;
        end else if (!empty) begin
            grant      = 1'b1;
            pop        = 1'b1;
            grant_reg  = head_reg;
            grant_data = head_data;
        end
    end

    always_comb begin
        state_nxt = state;
        age_nxt   = age;
        case (state)
            IDLE: begin
                age_nxt = '0;
                if (push) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (pop) begin
                    age_nxt   = '0;
                    state_nxt = remaining ? WAIT : IDLE;
                end else if (age == AGE_W'(MAX_WAIT)) begin
                    state_nxt = FORCE;
                end else begin
                    age_nxt = age + AGE_W'(1);
                end
            end
            FORCE: begin
                age_nxt   = '0;
                state_nxt = remaining ? WAIT : IDLE;
            end
            default: begin
                age_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            age   <= '0;
        end else begin
            state <= state_nxt;
            age   <= age_nxt;
        end
    end

    // R0 is hard-wired: the grant still retires but never strobes the write enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_reg  <= REG_ZERO;
            wr_data <= '0;
        end else begin
            wr_en <= grant && (grant_reg != REG_ZERO);
            if (grant) begin
                wr_reg  <= grant_reg;
                wr_data <= grant_data;
            end
        end
    end

endmodule
